riscv_5stage_hazard_control: RTL and testbench
==============================================

Name: riscv_5stage_hazard_control

Overview:
Parametrised pipeline-control successor to the 5-stage combinational decoder. It tracks a per-stage register-use scoreboard for the EX, MEM and WB stages and makes the stall, bubble and flush decisions. It also generates the EX-stage operand-forwarding selects and keeps saturating stall/flush performance counters. It sits beside the decoder: it reads the ID-stage instruction and the EX-stage redirect, and drives the pipeline-register enables and flushes.

Parameters:
REG_ADDR_W, 5, register-index width (1<<REG_ADDR_W architectural registers; index 0 is hard-wired zero).
FORWARD_EN, 1, 1 = EX/MEM and MEM/WB forwarding present; 0 = no forwarding, resolve every RAW hazard by stalling.
WB_BYPASS, 1, 1 = register file is write-before-read, so the WB stage never causes a hazard.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID-stage instruction valid
id_instruction  in  32  ID-stage instruction (RV32I encoding)
ex_redirect  in  1  EX resolved a taken branch, JAL or JALR this cycle
mem_busy  in  1  data memory not ready; freeze the whole pipeline
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  clear IF/ID register to a bubble
id_ex_bubble  out  1  load a bubble into ID/EX
ex_stall  out  1  hold ID/EX, EX/MEM, MEM/WB (equals mem_busy)
fwd_a_sel  out  2  EX op1 source: 0 regfile, 1 EX/MEM aluOut, 2 MEM/WB writeback
fwd_b_sel  out  2  EX op2 source, same encoding
stall_count  out  CNT_W  hazard-stall cycles, saturating
flush_count  out  CNT_W  redirect cycles, saturating

Behaviour:
- ID decode of the instruction fields:
  - rd = [11:7], rs1 = [19:15], rs2 = [24:20].
  - wen is set for LUI, AUIPC, JAL, JALR, OP-IMM, LOAD and OP; it is forced to 0 when rd==0 or id_valid==0.
  - memRead is set for LOAD.
  - use1 is set for all opcodes except LUI, AUIPC and JAL.
  - use2 is set for OP, BRANCH and STORE.
  - Unknown opcodes: wen=use1=use2=0.
- Scoreboard records (registered):
  - EX holds {v, rd, wen, memRead, rs1, rs2, use1, use2}.
  - MEM holds {v, rd, wen, memRead}.
  - WB holds {v, rd, wen}.
- match(S, r) = S.v & S.wen & (S.rd == r) & (r != 0).
- Hazard stall (hz), combinational:
  - FORWARD_EN=1: hz = EX.memRead & (use1&match(EX,rs1) | use2&match(EX,rs2)).
  - FORWARD_EN=0: hz = any use-qualified match against EX or MEM. WB is also included when WB_BYPASS=0.
  - hz is qualified by id_valid.
- Output priority, highest first:
  - mem_busy=1: pc_stall = if_id_stall = ex_stall = 1; flush and bubble outputs 0; all records and counters hold. ex_redirect is ignored and the EX stage holds it until mem_busy drops.
  - else ex_redirect=1: if_id_flush = id_ex_bubble = 1; stalls 0; hz is ignored because the ID instruction is killed.
  - else hz=1: pc_stall = if_id_stall = id_ex_bubble = 1.
  - else all 0.
- Record advance on clk with !rst and !mem_busy:
  - EX <= (id_ex_bubble ? invalid : ID decode).
  - MEM <= EX.
  - WB <= MEM.
- Forwarding (FORWARD_EN=1), for operand a (b is symmetric with rs2/use2):
  - fwd_a_sel = 1 if EX.use1 & match(MEM, EX.rs1) & !MEM.memRead.
  - else 2 if EX.use1 & match(WB, EX.rs1).
  - else 0.
  - MEM has priority over WB.
  - FORWARD_EN=0: both selects are always 0.
- Counters:
  - stall_count increments in a cycle where hz & !ex_redirect & !mem_busy.
  - flush_count increments in a cycle where ex_redirect & !mem_busy.
  - Both saturate at all-ones.
- Reset: all record v=0, counters 0. Consequently, with mem_busy=0 and ex_redirect=0, all outputs are 0 in the cycle after reset. Reset mid-stall discards all records.
- Latency: hazard and forward outputs are combinational from registered state plus the current inputs; decisions take effect at the next clk.

Test Plan:
- ALU-to-ALU forwarding: FORWARD_EN=1; issue add x5,x1,x2 then sub x6,x5,x3 back-to-back -> no stall; while sub is in EX, fwd_a_sel=1, fwd_b_sel=0.
- Load-use stall: lw x7,0(x1) then add x8,x7,x7 -> exactly one cycle of pc_stall=if_id_stall=id_ex_bubble=1; next cycle fwd_a_sel=fwd_b_sel=2; stall_count=1.
- No-forwarding mode: FORWARD_EN=0, WB_BYPASS=1; add x5,.. then add x6,x5,x0 -> 2 stall cycles; stall_count=2; selects stay 0.
- x0 and unused operands: writer addi x0,x0,1 followed by a reader of x0 -> no stall, sel 0. lui x9 followed by jal x1 (no sources) -> no stall.
- Redirect overrides stall: ex_redirect=1 in the same cycle as a load-use hz -> if_id_flush=id_ex_bubble=1, pc_stall=0, flush_count+1, stall_count unchanged.
- mem_busy freeze and counter saturation: hold mem_busy for 3 cycles during a pending forward -> records and selects are unchanged after release. With CNT_W=2, 5 stall cycles -> stall_count=3.

Source files
------------

// File: rtl/riscv_5stage_hazard_control.sv
// Pipeline hazard control for a 5-stage RV32I core.
// Tracks destination/source usage of the EX, MEM and WB stages and decides
// stalls, bubbles, flushes and EX operand forwarding. It also keeps saturating
// stall/flush performance counters.
module riscv_5stage_hazard_control #(
    parameter int REG_ADDR_W = 5,
    parameter int FORWARD_EN = 1,
    parameter int WB_BYPASS  = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_instruction,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wen;
        logic                  mrd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use1;
        logic                  use2;
    } ex_rec_t;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wen;
        logic                  mrd;
    } mem_rec_t;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wen;
    } wb_rec_t;

    // A stage produces register r: valid writer of a non-zero register.
    function automatic logic match_f(input logic v, input logic wen,
                                     input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] r);
        return v & wen & (rd == r) & (r != REG_ZERO);
    endfunction

    ex_rec_t  ex_q, ex_d, id_dec_s;
    mem_rec_t mem_q, mem_d;
    wb_rec_t  wb_q, wb_d;

    logic             hz_s;
    logic             pc_stall_s, if_id_stall_s, if_id_flush_s, id_ex_bubble_s, ex_stall_s;
    logic [1:0]       fwd_a_s, fwd_b_s;
    logic [CNT_W-1:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;
    logic             unused_s;

    // Funct fields never influence hazard decisions.
    assign unused_s = ^{id_instruction[31:25], id_instruction[14:12]};

    // Decode the ID-stage instruction into a candidate EX record.
    always_comb begin
        id_dec_s      = '0;
        id_dec_s.v    = id_valid;
        id_dec_s.rd   = id_instruction[7 +: REG_ADDR_W];
        id_dec_s.rs1  = id_instruction[15 +: REG_ADDR_W];
        id_dec_s.rs2  = id_instruction[20 +: REG_ADDR_W];
        case (id_instruction[6:0])
            OP_LUI, OP_AUIPC, OP_JAL: begin
                id_dec_s.wen  = 1'b1;
            end
            OP_JALR, OP_IMM: begin
                id_dec_s.wen  = 1'b1;
                id_dec_s.use1 = 1'b1;
            end
            OP_LOAD: begin
                id_dec_s.wen  = 1'b1;
                id_dec_s.mrd  = 1'b1;
                id_dec_s.use1 = 1'b1;
            end
            OP_OP: begin
                id_dec_s.wen  = 1'b1;
                id_dec_s.use1 = 1'b1;
                id_dec_s.use2 = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                id_dec_s.use1 = 1'b1;
                id_dec_s.use2 = 1'b1;
            end
            default: begin
                id_dec_s.wen  = 1'b0;
                id_dec_s.use1 = 1'b0;
                id_dec_s.use2 = 1'b0;
            end
        endcase
        // Writes to x0 or from an empty slot never create a dependency.
        if ((id_dec_s.rd == REG_ZERO) || !id_valid) begin
            id_dec_s.wen = 1'b0;
        end else begin
            id_dec_s.wen = id_dec_s.wen;
        end
    end

    // RAW hazard detection for the ID instruction against older stages.
    always_comb begin
        hz_s = 1'b0;
        if (FORWARD_EN != 0) begin
            // Only a load in EX cannot be forwarded in time.
            hz_s = ex_q.mrd &
                   ((id_dec_s.use1 & match_f(ex_q.v, ex_q.wen, ex_q.rd, id_dec_s.rs1)) |
                    (id_dec_s.use2 & match_f(ex_q.v, ex_q.wen, ex_q.rd, id_dec_s.rs2)));
        end else begin
            hz_s = (id_dec_s.use1 &
                    (match_f(ex_q.v, ex_q.wen, ex_q.rd, id_dec_s.rs1) |
                     match_f(mem_q.v, mem_q.wen, mem_q.rd, id_dec_s.rs1) |
                     ((WB_BYPASS == 0) & match_f(wb_q.v, wb_q.wen, wb_q.rd, id_dec_s.rs1)))) |
                   (id_dec_s.use2 &
                    (match_f(ex_q.v, ex_q.wen, ex_q.rd, id_dec_s.rs2) |
                     match_f(mem_q.v, mem_q.wen, mem_q.rd, id_dec_s.rs2) |
                     ((WB_BYPASS == 0) & match_f(wb_q.v, wb_q.wen, wb_q.rd, id_dec_s.rs2))));
        end
        hz_s = hz_s & id_valid;
    end

    // Prioritised pipeline control: memory freeze, then redirect, then hazard.
    always_comb begin
        pc_stall_s     = 1'b0;
        if_id_stall_s  = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        ex_stall_s     = 1'b0;
        if (mem_busy) begin
            pc_stall_s    = 1'b1;
            if_id_stall_s = 1'b1;
            ex_stall_s    = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
        end else if (hz_s) begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
        end else begin
            pc_stall_s     = 1'b0;
            if_id_stall_s  = 1'b0;
        end
    end

    // EX operand forwarding selects; MEM result wins over WB.
    always_comb begin
        fwd_a_s = 2'd0;
        fwd_b_s = 2'd0;
        if (FORWARD_EN != 0) begin
            if (ex_q.use1 & match_f(mem_q.v, mem_q.wen, mem_q.rd, ex_q.rs1) & !mem_q.mrd) begin
                fwd_a_s = 2'd1;
            end else if (ex_q.use1 & match_f(wb_q.v, wb_q.wen, wb_q.rd, ex_q.rs1)) begin
                fwd_a_s = 2'd2;
            end else begin
                fwd_a_s = 2'd0;
            end
            if (ex_q.use2 & match_f(mem_q.v, mem_q.wen, mem_q.rd, ex_q.rs2) & !mem_q.mrd) begin
                fwd_b_s = 2'd1;
            end else if (ex_q.use2 & match_f(wb_q.v, wb_q.wen, wb_q.rd, ex_q.rs2)) begin
                fwd_b_s = 2'd2;
            end else begin
                fwd_b_s = 2'd0;
            end
        end else begin
            fwd_a_s = 2'd0;
            fwd_b_s = 2'd0;
        end
    end

    // Next-state of the stage records and saturating counters.
    always_comb begin
        ex_d          = ex_q;
        mem_d         = mem_q;
        wb_d          = wb_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!mem_busy) begin
            ex_d  = id_ex_bubble_s ? ex_rec_t'('0) : id_dec_s;
            mem_d = '{v: ex_q.v, rd: ex_q.rd, wen: ex_q.wen, mrd: ex_q.mrd};
            wb_d  = '{v: mem_q.v, rd: mem_q.rd, wen: mem_q.wen};
            if (hz_s && !ex_redirect && (stall_count_q != CNT_MAX)) begin
                stall_count_d = stall_count_q + CNT_ONE;
            end else begin
                stall_count_d = stall_count_q;
            end
            if (ex_redirect && (flush_count_q != CNT_MAX)) begin
                flush_count_d = flush_count_q + CNT_ONE;
            end else begin
                flush_count_d = flush_count_q;
            end
        end else begin
            ex_d  = ex_q;
            mem_d = mem_q;
            wb_d  = wb_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign pc_stall     = pc_stall_s;
    assign if_id_stall  = if_id_stall_s;
    assign if_id_flush  = if_id_flush_s;
    assign id_ex_bubble = id_ex_bubble_s;
    assign ex_stall     = ex_stall_s;
    assign fwd_a_sel    = fwd_a_s;
    assign fwd_b_sel    = fwd_b_s;
    assign stall_count  = stall_count_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_riscv_5stage_hazard_control.sv
// Directed self-checking bench: one default instance, one without forwarding,
// and one with 2-bit counters, all driven by the same stimulus.
module tb_riscv_5stage_hazard_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic        ex_redirect;
    logic        mem_busy;

    logic        a_pcs, a_ifs, a_iff, a_bub, a_exs;
    logic [1:0]  a_fa, a_fb;
    logic [15:0] a_sc, a_fc;
    logic        b_pcs, b_ifs, b_iff, b_bub, b_exs;
    logic [1:0]  b_fa, b_fb;
    logic [15:0] b_sc, b_fc;
    logic        c_pcs, c_ifs, c_iff, c_bub, c_exs;
    logic [1:0]  c_fa, c_fb;
    logic [1:0]  c_sc, c_fc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    riscv_5stage_hazard_control #(.FORWARD_EN(1), .WB_BYPASS(1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instruction(id_instruction),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_stall(a_pcs), .if_id_stall(a_ifs), .if_id_flush(a_iff), .id_ex_bubble(a_bub),
        .ex_stall(a_exs), .fwd_a_sel(a_fa), .fwd_b_sel(a_fb),
        .stall_count(a_sc), .flush_count(a_fc));

    riscv_5stage_hazard_control #(.FORWARD_EN(0), .WB_BYPASS(1), .CNT_W(16)) u_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instruction(id_instruction),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_stall(b_pcs), .if_id_stall(b_ifs), .if_id_flush(b_iff), .id_ex_bubble(b_bub),
        .ex_stall(b_exs), .fwd_a_sel(b_fa), .fwd_b_sel(b_fb),
        .stall_count(b_sc), .flush_count(b_fc));

    riscv_5stage_hazard_control #(.FORWARD_EN(1), .WB_BYPASS(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instruction(id_instruction),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_stall(c_pcs), .if_id_stall(c_ifs), .if_id_flush(c_iff), .id_ex_bubble(c_bub),
        .ex_stall(c_exs), .fwd_a_sel(c_fa), .fwd_b_sel(c_fb),
        .stall_count(c_sc), .flush_count(c_fc));

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic redir, input logic busy);
        id_valid       = v;
        id_instruction = ins;
        ex_redirect    = redir;
        mem_busy       = busy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0000_0000, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] i_add5, i_sub6, i_lw7, i_add8, i_add6x0, i_addi0, i_add10, i_lui9, i_jal1;

    initial begin
        i_add5   = enc_r(7'h00, 5'd5, 5'd1, 5'd2);
        i_sub6   = enc_r(7'h20, 5'd6, 5'd5, 5'd3);
        i_lw7    = enc_i(7'b0000011, 5'd7, 5'd1, 12'd0);
        i_add8   = enc_r(7'h00, 5'd8, 5'd7, 5'd7);
        i_add6x0 = enc_r(7'h00, 5'd6, 5'd5, 5'd0);
        i_addi0  = enc_i(7'b0010011, 5'd0, 5'd0, 12'd1);
        i_add10  = enc_r(7'h00, 5'd10, 5'd0, 5'd0);
        i_lui9   = enc_u(7'b0110111, 5'd9, 20'h12345);
        i_jal1   = enc_u(7'b1101111, 5'd1, 20'h00048); // rs1 field looks like x9

        // Reset state
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("rst_ctrl", {a_pcs, a_ifs, a_iff, a_bub, a_exs}, 32'd0);
        check_eq("rst_fwd", {a_fa, a_fb}, 32'd0);
        check_eq("rst_cnt", {a_sc, a_fc}, 32'd0);

        // ALU-to-ALU forwarding
        drive(1'b1, i_add5, 1'b0, 1'b0);
        tick();
        drive(1'b1, i_sub6, 1'b0, 1'b0);
        check_eq("alu_nostall", a_pcs, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("alu_fwd_a", a_fa, 32'd1);
        check_eq("alu_fwd_b", a_fb, 32'd0);

        // Load-use stall
        do_reset();
        drive(1'b1, i_lw7, 1'b0, 1'b0);
        tick();
        drive(1'b1, i_add8, 1'b0, 1'b0);
        check_eq("lu_stall", {a_pcs, a_ifs, a_bub, a_iff}, 32'b1110);
        tick();
        drive(1'b1, i_add8, 1'b0, 1'b0);
        check_eq("lu_release", {a_pcs, a_ifs, a_bub}, 32'd0);
        check_eq("lu_cnt", a_sc, 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("lu_fwd_a", a_fa, 32'd2);
        check_eq("lu_fwd_b", a_fb, 32'd2);

        // No-forwarding mode: two stall cycles
        do_reset();
        drive(1'b1, i_add5, 1'b0, 1'b0);
        tick();
        drive(1'b1, i_add6x0, 1'b0, 1'b0);
        check_eq("nf_stall1", {b_pcs, b_ifs, b_bub}, 32'b111);
        check_eq("nf_fwd_on_nostall", a_pcs, 32'd0);
        tick();
        drive(1'b1, i_add6x0, 1'b0, 1'b0);
        check_eq("nf_stall2", {b_pcs, b_ifs, b_bub}, 32'b111);
        tick();
        drive(1'b1, i_add6x0, 1'b0, 1'b0);
        check_eq("nf_release", b_pcs, 32'd0);
        check_eq("nf_cnt", b_sc, 32'd2);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("nf_sel", {b_fa, b_fb}, 32'd0);

        // x0 and unused operands
        do_reset();
        drive(1'b1, i_addi0, 1'b0, 1'b0);
        tick();
        drive(1'b1, i_add10, 1'b0, 1'b0);
        check_eq("x0_nostall_nf", b_pcs, 32'd0);
        tick();
        drive(1'b1, i_lui9, 1'b0, 1'b0);
        check_eq("x0_sel", {a_fa, a_fb}, 32'd0);
        tick();
        drive(1'b1, i_jal1, 1'b0, 1'b0);
        check_eq("jal_nostall_nf", b_pcs, 32'd0);
        tick();

        // Redirect overrides a load-use hazard
        do_reset();
        drive(1'b1, i_lw7, 1'b0, 1'b0);
        tick();
        drive(1'b1, i_add8, 1'b1, 1'b0);
        check_eq("rd_ctrl", {a_iff, a_bub, a_pcs, a_ifs}, 32'b1100);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("rd_flush_cnt", a_fc, 32'd1);
        check_eq("rd_stall_cnt", a_sc, 32'd0);

        // mem_busy freeze with a pending forward
        do_reset();
        drive(1'b1, i_add5, 1'b0, 1'b0);
        tick();
        drive(1'b1, i_sub6, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i_lw7, (i == 1), 1'b1);
            check_eq("busy_ctrl", {a_pcs, a_ifs, a_exs, a_iff, a_bub}, 32'b11100);
            check_eq("busy_fwd_a", a_fa, 32'd1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("busy_after_fwd", {a_fa, a_fb}, 32'b0100);
        check_eq("busy_flush_cnt", a_fc, 32'd0);

        // Counter saturation: five load-use stalls
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, i_lw7, 1'b0, 1'b0);
            tick();
            drive(1'b1, i_add8, 1'b0, 1'b0);
            tick();
            drive(1'b1, i_add8, 1'b0, 1'b0);
            tick();
            if (k == 1) check_eq("sat_cnt2", c_sc, 32'd2);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("sat_cnt", c_sc, 32'd3);
        check_eq("wide_cnt", a_sc, 32'd5);

        // Mid-stall reset discards records
        drive(1'b1, i_lw7, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, i_add8, 1'b0, 1'b0);
        check_eq("rst_mid_stall", {a_pcs, a_bub}, 32'd0);
        check_eq("rst_mid_cnt", a_sc, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
